// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered outputs, optional zero register
// and optional same-edge write forwarding. Storage and outputs clear asynchronously.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           WE_i,
    input  logic [ADDR_WIDTH-1:0]          addrDest_i,
    input  logic [DATA_WIDTH-1:0]          dataDest_i,
    input  logic                           stall_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   addrSrc_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]   dataSrc_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_wr_en;

    assign w_wr_en = WE_i && !((ZERO_REG != 0) && (addrDest_i == '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[addrDest_i] <= dataDest_i;
        end
    end

    genvar k;
    for (k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_val;
        logic [DATA_WIDTH-1:0] r_q;

        assign w_addr = addrSrc_i[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Zero register takes priority over forwarding so a discarded r0 write never leaks out.
        always_comb begin
            w_val = r_mem[w_addr];
            if ((BYPASS != 0) && WE_i && (addrDest_i == w_addr)) begin
                w_val = dataDest_i;
            end
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_val = '0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_q <= '0;
            end else if (!stall_i) begin
                r_q <= w_val;
            end
        end

        assign dataSrc_o[k*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven against a per-edge reference
// model of the register file (array of entries plus expected operand per port).
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    // dut_a: ZERO_REG=1, BYPASS=1, 4 ports; dut_b: ZERO_REG=0, BYPASS=0, 2 ports (shares stimulus)
    logic         we_ab;
    logic [4:0]   wa_ab;
    logic [31:0]  wd_ab;
    logic         st_ab;
    logic [19:0]  addr_ab;
    logic [127:0] dsrc_a;
    logic [63:0]  dsrc_b;

    // dut_c: 64-bit, 8 entries, 3 ports
    logic         we_c;
    logic [2:0]   wa_c;
    logic [63:0]  wd_c;
    logic         st_c;
    logic [8:0]   addr_c;
    logic [191:0] dsrc_c;

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    logic [63:0] mem_c [8];
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [2];
    logic [63:0] exp_c [3];

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .WE_i(we_ab), .addrDest_i(wa_ab), .dataDest_i(wd_ab),
        .stall_i(st_ab), .addrSrc_i(addr_ab), .dataSrc_o(dsrc_a));

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .WE_i(we_ab), .addrDest_i(wa_ab), .dataDest_i(wd_ab),
        .stall_i(st_ab), .addrSrc_i(addr_ab[9:0]), .dataSrc_o(dsrc_b));

    regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .WE_i(we_c), .addrDest_i(wa_c), .dataDest_i(wd_c),
        .stall_i(st_c), .addrSrc_i(addr_c), .dataSrc_o(dsrc_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        for (int i = 0; i < 8; i++) mem_c[i] = '0;
        for (int k = 0; k < 4; k++) exp_a[k] = '0;
        for (int k = 0; k < 2; k++) exp_b[k] = '0;
        for (int k = 0; k < 3; k++) exp_c[k] = '0;
    endtask

    // One clock edge on dut_a/dut_b; operands are chosen from pre-edge contents, then the write lands.
    task automatic cycle_ab(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic st, input logic [19:0] addrs);
        logic [4:0] a;
        we_ab = we; wa_ab = wa; wd_ab = wd; st_ab = st; addr_ab = addrs;
        @(posedge clk);
        if (!st) begin
            for (int k = 0; k < 4; k++) begin
                a = addrs[k*5 +: 5];
                if (a == 0)                exp_a[k] = '0;
                else if (we && wa == a)    exp_a[k] = wd;
                else                       exp_a[k] = mem_a[a];
            end
            for (int k = 0; k < 2; k++) exp_b[k] = mem_b[addrs[k*5 +: 5]];
        end
        if (we) begin
            if (wa != 0) mem_a[wa] = wd;
            mem_b[wa] = wd;
        end
        #1;
    endtask

    task automatic cycle_c(input logic we, input logic [2:0] wa, input logic [63:0] wd,
                           input logic st, input logic [8:0] addrs);
        logic [2:0] a;
        we_c = we; wa_c = wa; wd_c = wd; st_c = st; addr_c = addrs;
        @(posedge clk);
        if (!st) begin
            for (int k = 0; k < 3; k++) begin
                a = addrs[k*3 +: 3];
                if (a == 0)                exp_c[k] = '0;
                else if (we && wa == a)    exp_c[k] = wd;
                else                       exp_c[k] = mem_c[a];
            end
        end
        if (we && wa != 0) mem_c[wa] = wd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (dsrc_a[k*32 +: 32] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_a port %0d: got %h expected 0", k, dsrc_a[k*32 +: 32]);
            end
        end
        n_tests++;
        if (dsrc_b !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0", dsrc_b);
        end
        n_tests++;
        if (dsrc_c !== 192'h0) begin
            n_fail++;
            $display("FAIL reset_c: got %h expected 0", dsrc_c);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset_clear();
        cycle_ab(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, {5'd0, 5'd0, 5'd5, 5'd5});
        cycle_ab(1'b0, 5'd0, 32'h0, 1'b0, {5'd0, 5'd0, 5'd5, 5'd5});
        n_tests++;
        if (dsrc_a[31:0] !== 32'hDEADBEEF || dsrc_b[31:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL preclear_r5: got a=%h b=%h expected deadbeef", dsrc_a[31:0], dsrc_b[31:0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (dsrc_a !== 128'h0 || dsrc_b !== 64'h0) begin
            n_fail++;
            $display("FAIL async_clear: got a=%h b=%h expected 0", dsrc_a, dsrc_b);
        end
        model_clear();
        #1 rst_n = 1'b1;
        cycle_ab(1'b0, 5'd0, 32'h0, 1'b0, {5'd0, 5'd0, 5'd0, 5'd5});
        n_tests++;
        if (dsrc_a[31:0] !== 32'h0 || dsrc_b[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL read_after_clear: got a=%h b=%h expected 0", dsrc_a[31:0], dsrc_b[31:0]);
        end
    endtask

    task automatic test_basic();
        logic [31:0] want [4];
        want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'hFFFFFFFF;
        cycle_ab(1'b1, 5'd1,  32'h11,       1'b0, 20'h0);
        cycle_ab(1'b1, 5'd2,  32'h22,       1'b0, 20'h0);
        cycle_ab(1'b1, 5'd3,  32'h33,       1'b0, 20'h0);
        cycle_ab(1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 20'h0);
        cycle_ab(1'b0, 5'd0,  32'h0,        1'b0, {5'd31, 5'd3, 5'd2, 5'd1});
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (dsrc_a[k*32 +: 32] !== want[k]) begin
                n_fail++;
                $display("FAIL basic_a port %0d: got %h expected %h", k, dsrc_a[k*32 +: 32], want[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dsrc_b[k*32 +: 32] !== want[k]) begin
                n_fail++;
                $display("FAIL basic_b port %0d: got %h expected %h", k, dsrc_b[k*32 +: 32], want[k]);
            end
        end
    endtask

    task automatic test_zero_reg();
        cycle_ab(1'b1, 5'd0, 32'h1234, 1'b0, 20'h0);
        n_tests++;
        if (dsrc_a[31:0] !== 32'h0 || dsrc_b[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_same_edge: got a=%h b=%h expected 0/0", dsrc_a[31:0], dsrc_b[31:0]);
        end
        cycle_ab(1'b0, 5'd0, 32'h0, 1'b0, 20'h0);
        n_tests++;
        if (dsrc_a[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_next_a: got %h expected 0", dsrc_a[31:0]);
        end
        n_tests++;
        if (dsrc_b[31:0] !== 32'h1234) begin
            n_fail++;
            $display("FAIL zero_next_b: got %h expected 1234", dsrc_b[31:0]);
        end
    endtask

    task automatic test_bypass();
        cycle_ab(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, {5'd0, 5'd0, 5'd7, 5'd7});
        n_tests++;
        if (dsrc_a[63:0] !== {2{32'hA5A5A5A5}}) begin
            n_fail++;
            $display("FAIL bypass_a: got %h expected a5a5a5a5 x2", dsrc_a[63:0]);
        end
        n_tests++;
        if (dsrc_b !== 64'h0) begin
            n_fail++;
            $display("FAIL nobypass_b_old: got %h expected 0", dsrc_b);
        end
        cycle_ab(1'b0, 5'd0, 32'h0, 1'b0, {5'd0, 5'd0, 5'd7, 5'd7});
        n_tests++;
        if (dsrc_b !== {2{32'hA5A5A5A5}}) begin
            n_fail++;
            $display("FAIL nobypass_b_next: got %h expected a5a5a5a5 x2", dsrc_b);
        end
    endtask

    task automatic test_stall();
        cycle_ab(1'b1, 5'd4, 32'h44, 1'b0, 20'h0);
        cycle_ab(1'b0, 5'd0, 32'h0,  1'b0, {5'd0, 5'd0, 5'd0, 5'd4});
        for (int c = 0; c < 3; c++) begin
            cycle_ab(c == 0, 5'd4, 32'h55, 1'b1, {5'd0, 5'd0, 5'd0, 5'd1});
            n_tests++;
            if (dsrc_a[31:0] !== 32'h44 || dsrc_b[31:0] !== 32'h44) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d: got a=%h b=%h expected 44", c, dsrc_a[31:0], dsrc_b[31:0]);
            end
        end
        cycle_ab(1'b0, 5'd0, 32'h0, 1'b0, {5'd0, 5'd0, 5'd0, 5'd1});
        n_tests++;
        if (dsrc_a[31:0] !== 32'h11 || dsrc_b[31:0] !== 32'h11) begin
            n_fail++;
            $display("FAIL stall_release: got a=%h b=%h expected 11", dsrc_a[31:0], dsrc_b[31:0]);
        end
        cycle_ab(1'b0, 5'd0, 32'h0, 1'b0, {5'd0, 5'd0, 5'd0, 5'd4});
        n_tests++;
        if (dsrc_a[31:0] !== 32'h55 || dsrc_b[31:0] !== 32'h55) begin
            n_fail++;
            $display("FAIL stall_write: got a=%h b=%h expected 55", dsrc_a[31:0], dsrc_b[31:0]);
        end
    endtask

    task automatic test_random();
        logic [19:0] addrs;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 4; k++) addrs[k*5 +: 5] = 5'($urandom_range(0, 7));
            cycle_ab(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 3) == 0, addrs);
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (dsrc_a[k*32 +: 32] !== exp_a[k]) begin
                    n_fail++;
                    $display("FAIL random_a cyc %0d port %0d: got %h expected %h", c, k, dsrc_a[k*32 +: 32], exp_a[k]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dsrc_b[k*32 +: 32] !== exp_b[k]) begin
                    n_fail++;
                    $display("FAIL random_b cyc %0d port %0d: got %h expected %h", c, k, dsrc_b[k*32 +: 32], exp_b[k]);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [63:0] want;
        logic [8:0]  addrs;
        for (int i = 0; i < 8; i++) cycle_c(1'b1, 3'(i), 64'(i) * 64'h0101010101010101, 1'b0, 9'h0);
        for (int e = 0; e < 8; e++) begin
            cycle_c(1'b0, 3'd0, 64'h0, 1'b0, {3'(e), 3'(e), 3'(e)});
            want = 64'(e) * 64'h0101010101010101;
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (dsrc_c[k*64 +: 64] !== want) begin
                    n_fail++;
                    $display("FAIL sweep entry %0d port %0d: got %h expected %h", e, k, dsrc_c[k*64 +: 64], want);
                end
            end
        end
        for (int c = 0; c < 150; c++) begin
            for (int k = 0; k < 3; k++) addrs[k*3 +: 3] = 3'($urandom_range(0, 7));
            cycle_c(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                    $urandom_range(0, 3) == 0, addrs);
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (dsrc_c[k*64 +: 64] !== exp_c[k]) begin
                    n_fail++;
                    $display("FAIL random_c cyc %0d port %0d: got %h expected %h", c, k, dsrc_c[k*64 +: 64], exp_c[k]);
                end
            end
        end
    endtask

    initial begin
        we_ab = 1'b0; wa_ab = '0; wd_ab = '0; st_ab = 1'b0; addr_ab = '0;
        we_c = 1'b0;  wa_c = '0;  wd_c = '0;  st_c = 1'b0;  addr_c = '0;
        model_clear();
        test_reset();
        test_reset_clear();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_stall();
        test_random();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
